mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 51 +++++
 rtl/mdu_if.sv | 14 +
 rtl/mdu_calc.sv | 57 +++++
 rtl/mdu.sv | 93 +++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op encodings, state type and op-class helpers (madd/maddu gated by MDU_MADD_EN)
package mdu_pkg;

  // Shared op encodings; the decoder and the stall unit use the same values.
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } md_op_e;

  // Instruction class seen by the stall unit in the D stage.
  typedef enum logic {
    INSTR_OTHER = 1'b0,
    INSTR_MD    = 1'b1
  } instr_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for MULT_CYCLES.
  function automatic logic is_mult_op(input md_op_e op);
    case (op)
      OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: return 1'b1;
`endif
      default:           return 1'b0;
    endcase
  endfunction

  // Ops that occupy the unit for DIV_CYCLES.
  function automatic logic is_div_op(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // A D-stage md instruction must wait while the unit is busy or being started.
  function automatic logic md_stall(input instr_type_e d_type, input logic busy, input logic start);
    return (d_type == INSTR_MD) && (busy || start);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - E-stage request/response bundle between the pipeline and the MDU
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  md_op_e      op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] out;

  modport master (output start, op, A, B, input busy, out);
  modport slave  (input start, op, A, B, output busy, out);
endinterface

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational mult/div/move datapath producing next HI/LO (accumulate under MDU_MADD_EN)
module mdu_calc
  import mdu_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic               b_zero;

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};
  assign quo_s  = $signed(a_i) / $signed(b_i);
  assign rem_s  = $signed(a_i) % $signed(b_i);
  assign quo_u  = a_i / b_i;
  assign rem_u  = a_i % b_i;
  assign b_zero = (b_i == 32'd0);

`ifdef MDU_MADD_EN
  logic [63:0] acc_s;
  logic [63:0] acc_u;
  assign acc_s = {hi_i, lo_i} + prod_s;
  assign acc_u = {hi_i, lo_i} + prod_u;
`endif

  // Select the result; divide-by-zero and non-arithmetic ops pass HI/LO through.
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    case (op_i)
      OP_MULT:  {hi_o, lo_o} = prod_s;
      OP_MULTU: {hi_o, lo_o} = prod_u;
      OP_DIV:   if (!b_zero) begin hi_o = rem_s; lo_o = quo_s; end
      OP_DIVU:  if (!b_zero) begin hi_o = rem_u; lo_o = quo_u; end
      OP_MTHI:  hi_o = a_i;
      OP_MTLO:  lo_o = a_i;
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_o, lo_o} = acc_s;
      OP_MADDU: {hi_o, lo_o} = acc_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle HI/LO multiply-divide unit with busy timing (madd/maddu when MDU_MADD_EN is defined)
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;

  mdu_calc u_calc (
    .op_i (bus.op),
    .a_i  (bus.A),
    .b_i  (bus.B),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (calc_hi),
    .lo_o (calc_lo)
  );

  assign bus.busy = (state_q == ST_RUN);
  assign bus.out  = (bus.op == OP_MFHI) ? hi_q :
                    (bus.op == OP_MFLO) ? lo_q : 32'd0;

  // State and HI/LO registers; reset drops any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  // Accept work in IDLE, count down in RUN and commit the pending result on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_mult_op(bus.op) || is_div_op(bus.op)) begin
            phi_d   = calc_hi;
            plo_d   = calc_lo;
            cnt_d   = is_div_op(bus.op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d = ST_RUN;
          end else if (bus.op == OP_MTHI) begin
            hi_d = calc_hi;
          end else if (bus.op == OP_MTLO) begin
            lo_d = calc_lo;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
